// File: rtl/fx2_slavefifo_emu.sv
// Responder model of the FX2 slave-FIFO endpoint pair (EP6 OUT, EP2 IN) for loopback self-test.
// Define FX2EMU_PKTSTAT_EN to enable the committed-packet length statistic on last_pkt_len.
module fx2_slavefifo_emu #(
   parameter int unsigned AW   = 9,
   parameter int unsigned PKTW = 16
) (
   input  logic            clk,
   input  logic            reset_i,
   input  logic            sloe,
   input  logic            slrd,
   input  logic            slwr,
   input  logic [1:0]      fifoadr,
   input  logic            pktend,
   output logic            flaga,
   output logic            flagb,
   input  logic [7:0]      fd_i,
   output logic [7:0]      fd_o,
   output logic            fd_oe,
   input  logic [7:0]      host_wr_data,
   input  logic            host_wr_en,
   output logic            host_wr_full,
   output logic [7:0]      host_rd_data,
   output logic            host_rd_valid,
   input  logic            host_rd_en,
   output logic [PKTW-1:0] pkt_count,
   input  logic            err_clr,
   output logic [3:0]      err_flags,
   output logic [AW:0]     last_pkt_len
);

   localparam logic [AW:0]     CntFull = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]     CntOne  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0]   PtrOne  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [PKTW-1:0] PktOne  = {{(PKTW-1){1'b0}}, 1'b1};

   logic [7:0] ep6_mem [2**AW];
   logic [7:0] ep2_mem [2**AW];

   logic [AW-1:0]   ep6_wr_q, ep6_wr_d, ep6_rd_q, ep6_rd_d;
   logic [AW-1:0]   ep2_wr_q, ep2_wr_d, ep2_rd_q, ep2_rd_d;
   logic [AW:0]     ep6_cnt_q, ep6_cnt_d, ep2_cnt_q, ep2_cnt_d;
   logic [PKTW-1:0] pkt_q, pkt_d;
   logic [3:0]      err_q, err_d;

   logic both_low, sel_ep6, sel_ep2, rd_req, wr_req, commit;
   logic ep6_empty, ep6_full, ep2_empty, ep2_full;
   logic ep6_push, ep6_pop, ep2_push, ep2_pop;

   always_comb begin
      both_low  = ~slrd & ~slwr;
      sel_ep6   = (fifoadr == 2'b10);
      sel_ep2   = (fifoadr == 2'b00);
      ep6_empty = (ep6_cnt_q == '0);
      ep6_full  = (ep6_cnt_q == CntFull);
      ep2_empty = (ep2_cnt_q == '0);
      ep2_full  = (ep2_cnt_q == CntFull);
      // Conflicting strobes cancel both transfers.
      rd_req    = ~slrd & sel_ep6 & ~both_low;
      wr_req    = ~slwr & sel_ep2 & ~both_low;
      commit    = ~pktend & sel_ep2;
      // Pops qualify on the registered count, so a push into an empty FIFO never falls through.
      ep6_pop   = rd_req & ~ep6_empty;
      ep6_push  = host_wr_en & ~ep6_full;
      ep2_push  = wr_req & ~ep2_full;
      ep2_pop   = host_rd_en & ~ep2_empty;
   end

   always_comb begin
      ep6_wr_d  = ep6_push ? ep6_wr_q + PtrOne : ep6_wr_q;
      ep6_rd_d  = ep6_pop  ? ep6_rd_q + PtrOne : ep6_rd_q;
      ep2_wr_d  = ep2_push ? ep2_wr_q + PtrOne : ep2_wr_q;
      ep2_rd_d  = ep2_pop  ? ep2_rd_q + PtrOne : ep2_rd_q;
      ep6_cnt_d = ep6_cnt_q;
      if (ep6_push && !ep6_pop) ep6_cnt_d = ep6_cnt_q + CntOne;
      else if (ep6_pop && !ep6_push) ep6_cnt_d = ep6_cnt_q - CntOne;
      ep2_cnt_d = ep2_cnt_q;
      if (ep2_push && !ep2_pop) ep2_cnt_d = ep2_cnt_q + CntOne;
      else if (ep2_pop && !ep2_push) ep2_cnt_d = ep2_cnt_q - CntOne;
      pkt_d = commit ? pkt_q + PktOne : pkt_q;
      // A same-edge error event overrides err_clr.
      err_d = (err_clr ? 4'b0000 : err_q)
            | {both_low, host_wr_en & ep6_full, wr_req & ep2_full, rd_req & ep6_empty};
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         ep6_wr_q  <= '0;
         ep6_rd_q  <= '0;
         ep2_wr_q  <= '0;
         ep2_rd_q  <= '0;
         ep6_cnt_q <= '0;
         ep2_cnt_q <= '0;
         pkt_q     <= '0;
         err_q     <= '0;
      end else begin
         ep6_wr_q  <= ep6_wr_d;
         ep6_rd_q  <= ep6_rd_d;
         ep2_wr_q  <= ep2_wr_d;
         ep2_rd_q  <= ep2_rd_d;
         ep6_cnt_q <= ep6_cnt_d;
         ep2_cnt_q <= ep2_cnt_d;
         pkt_q     <= pkt_d;
         err_q     <= err_d;
      end
   end

   // Buffer storage carries no reset; occupancy counts define what is valid.
   always_ff @(posedge clk) begin
      if (ep6_push) ep6_mem[ep6_wr_q] <= host_wr_data;
      if (ep2_push) ep2_mem[ep2_wr_q] <= fd_i;
   end

`ifdef FX2EMU_PKTSTAT_EN
   logic [AW:0] acc_q, acc_d, acc_inc, len_q, len_d;

   always_comb begin
      acc_inc = (ep2_push && acc_q != CntFull) ? acc_q + CntOne : acc_q;
      acc_d   = commit ? '0 : acc_inc;
      len_d   = commit ? acc_inc : len_q;
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         acc_q <= '0;
         len_q <= '0;
      end else begin
         acc_q <= acc_d;
         len_q <= len_d;
      end
   end

   assign last_pkt_len = len_q;
`else
   assign last_pkt_len = '0;
`endif

   assign flaga         = ~ep2_full;
   assign flagb         = ~ep6_empty;
   assign fd_oe         = ~reset_i & ~sloe & sel_ep6;
   assign fd_o          = ep6_mem[ep6_rd_q];
   assign host_rd_data  = ep2_mem[ep2_rd_q];
   assign host_wr_full  = ep6_full;
   assign host_rd_valid = ~ep2_empty;
   assign pkt_count     = pkt_q;
   assign err_flags     = err_q;

endmodule

// File: doc/fx2_slavefifo_emu.md
Name: fx2_slavefifo_emu

Overview:
Synthesizable responder model of the FX2 slave-FIFO endpoint pair that the capture interface masters over sloe/slrd/slwr/fifoadr/pktend/flaga/flagb/fd.
- EP6 (OUT, host->FPGA): loaded from a host-side write port; drained by the master via slrd.
- EP2 (IN, FPGA->host): filled by the master via slwr; drained by a host-side read port.
- Used for hardware self-test and bench loopback of the capture interface without a physical FX2.

Parameters:
AW, 9, log2 of each endpoint FIFO depth (512 bytes, matching an FX2 buffer).
PKTW, 16, width of the committed-packet counter.

Ports:
clk  input  1  single clock; the master's interface clock.
reset_i  input  1  asynchronous, active-high reset.
sloe  input  1  active-low output enable from master.
slrd  input  1  active-low read strobe.
slwr  input  1  active-low write strobe.
fifoadr  input  2  endpoint select: 2'b00=EP2, 2'b10=EP6; others select nothing.
pktend  input  1  active-low packet commit.
flaga  output  1  EP2 full flag, active low (0 = full).
flagb  output  1  EP6 empty flag, active low (0 = empty).
fd_i  input  8  data from master.
fd_o  output  8  data to master (EP6 head).
fd_oe  output  1  drive enable for fd.
host_wr_data  input  8  byte to push into EP6.
host_wr_en  input  1  push strobe.
host_wr_full  output  1  EP6 full.
host_rd_data  output  8  EP2 head (first-word fall-through).
host_rd_valid  output  1  EP2 not empty.
host_rd_en  input  1  pop strobe.
pkt_count  output  PKTW  number of pktend commits on EP2; wraps.
err_clr  input  1  synchronous clear of sticky errors.
err_flags  output  4  sticky: [0] EP6 underflow, [1] EP2 overflow, [2] EP6 host overflow, [3] slrd and slwr both low.
last_pkt_len  output  AW+1  byte length of last committed packet (see Optional Feature).

Behaviour:
- Both FIFOs are circular buffers with AW-bit pointers and an (AW+1)-bit occupancy count. Count ranges 0..2^AW.
- Full: count == 2^AW. Empty: count == 0.
- Reset values:
  - counts, pointers, pkt_count, err_flags, last_pkt_len = 0.
  - flaga = 1; flagb = 0; fd_oe = 0; host_rd_valid = 0; host_wr_full = 0.
  - fd_o and host_rd_data are don't-care while empty.
- Reset asserted mid-transfer discards all buffered data immediately.
- Flags are decoded from registered counts:
  - flaga = ~EP2full; flagb = ~EP6empty.
  - A push or pop changes the flags in the cycle after its clock edge.
- fd_oe = ~sloe & (fifoadr==2'b10). This is combinational.
  - fd_o = EP6 head (FWFT), valid whenever flagb = 1.
- EP6 master read: on a clk edge with slrd=0, fifoadr=2'b10 and EP6 not empty, pop one byte. fd_o shows the next byte after that edge.
  - slrd=0 while empty: no pop; set err[0].
- EP2 master write: on a clk edge with slwr=0, fifoadr=2'b00 and EP2 not full, push fd_i.
  - slwr=0 while full: byte dropped; set err[1].
- Strobes with any other fifoadr are ignored without error.
- slrd=0 and slwr=0 on the same edge: both ignored; set err[3].
- pktend=0 with fifoadr=2'b00 on an edge: pkt_count increments (wrapping at 2^PKTW).
  - A concurrent valid slwr byte belongs to the committed packet.
  - pktend held low for N edges commits N packets. The master produces single-cycle pulses.
  - Commits with zero bytes since the previous commit (ZLPs) still count.
- Host push: host_wr_en while EP6 full drops the byte and sets err[2].
- Host pop: host_rd_en with host_rd_valid=0 is ignored silently.
- Simultaneous push and pop on one FIFO in the same edge:
  - Both take effect and the count is unchanged.
  - Exception: if the FIFO is empty, only the push occurs (no fall-through bypass).
  - If the FIFO is full, only the pop occurs, and the dropped push sets its overflow error.
- err_clr clears err_flags. An error event on the same edge wins.

Optional Feature:
FX2EMU_PKTSTAT_EN:
- Defined:
  - A byte counter accumulates accepted EP2 writes since the last commit.
  - On a pktend commit, last_pkt_len loads that count, including any same-edge byte, and the accumulator restarts at 0.
  - The accumulator saturates at 2^AW.
- Undefined: last_pkt_len is tied to 0 and no counter logic is generated.

Test Plan:
1. Host pushes 0x11,0x22,0x33 into EP6; master sets fifoadr=2'b10, sloe=0, then pulses slrd for 3 cycles -> fd_o reads 0x11,0x22,0x33 in order; flagb goes 0 the cycle after the third pop; a 4th slrd sets err_flags[0].
2. Master writes 0xA0..0xA4 via slwr on EP2, then asserts pktend with the last write -> pkt_count=1; host pops 0xA0..0xA4; last_pkt_len=5 with FX2EMU_PKTSTAT_EN, 0 without.
3. Fill EP2 with 512 writes -> flaga=0 the next cycle; 513th write dropped and err_flags[1]=1; same-edge host pop plus slwr at full -> count becomes 511, err[1] set.
4. EP6 empty, host_wr_en and slrd on the same edge -> count=1, no pop, err[0]=1; next slrd pops the byte.
5. slrd=0 and slwr=0 together -> no FIFO change, err_flags[3]=1; err_clr -> err_flags=0.
6. Reset asserted mid-burst with EP6 count=100 and EP2 count=40 -> flagb=0, flaga=1, fd_oe=0, pkt_count=0 immediately, without waiting for a clk edge.
